wbm_burst_master: RTL and testbench

WBM_BURST_MASTER -- requirements
Module: wbm_burst_master

---
 rtl/wbm_burst_master.sv | 212 +++++++++++++++++++++
 tb/tb_wbm_burst_master.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_burst_master.sv
// Pipelined Wishbone burst master: takes one burst command and issues cmd_len+1 strobes with incrementing addresses.
// Write words stream in through wr_valid/wr_ready, and read words stream out through rd_valid (latency 1, no backpressure).
// Optional ack watchdog is compiled in when WBM_BURST_TIMEOUT_EN is defined.
module wbm_burst_master #(
  parameter int data_width_g = 8,
  parameter int addr_width_g = 10,
  parameter int blen_width_g = 9,
  parameter int timeout_g    = 255
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [addr_width_g-1:0] cmd_adr,
  input  logic [blen_width_g-1:0] cmd_len,
  input  logic                    cmd_tgc,
  input  logic                    cmd_tgd,
  input  logic [data_width_g-1:0] wr_dat,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [data_width_g-1:0] rd_dat,
  output logic                    rd_valid,
  output logic                    done,
  output logic                    err,
  output logic                    tmo,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [addr_width_g-1:0] wbm_adr_o,
  output logic [blen_width_g-1:0] wbm_tga_o,
  output logic [data_width_g-1:0] wbm_dat_o,
  output logic                    wbm_tgc_o,
  output logic                    wbm_tgd_o,
  input  logic [data_width_g-1:0] wbm_dat_i,
  input  logic                    wbm_stall_i,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i
);

  // Counters need one extra bit: a full burst is 2^blen_width_g words.
  localparam int CW = blen_width_g + 1;
  localparam logic [CW-1:0]           CNT_ONE = 1;
  localparam logic [addr_width_g-1:0] ADR_ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;

  state_t        state;
  logic [CW-1:0] stb_cnt;      // strobes accepted by the slave
  logic [CW-1:0] ack_cnt;      // acks counted against accepted strobes
  logic [CW-1:0] total;        // words in the burst (tga holds cmd_len)
  logic [CW-1:0] stb_cnt_nxt;
  logic [CW-1:0] ack_cnt_nxt;
  logic          busy;
  logic          accept;
  logic          slot_free;
  logic          ack_ok;
  logic          tmo_hit;
  logic          abort;
  logic          load;

  assign total       = {1'b0, wbm_tga_o} + CNT_ONE;
  assign busy        = (state == ISSUE) || (state == WAIT_ACK);
  assign accept      = (state == ISSUE) && wbm_stb_o && !wbm_stall_i;
  assign stb_cnt_nxt = stb_cnt + (accept ? CNT_ONE : '0);
  // The output register may take a new strobe when empty or when its strobe leaves this cycle.
  assign slot_free   = !wbm_stb_o || !wbm_stall_i;
  // Acks are only meaningful against strobes already accepted; stray ones are dropped.
  assign ack_ok      = busy && wbm_ack_i && (ack_cnt < stb_cnt);
  assign ack_cnt_nxt = ack_cnt + (ack_ok ? CNT_ONE : '0);
  assign abort       = busy && (wbm_err_i || tmo_hit);
  // Present another strobe only while words remain; writes also need a word on wr_dat.
  assign load        = (state == ISSUE) && slot_free && (stb_cnt_nxt < total) && !abort &&
                       (!wbm_we_o || wr_valid);
  // wr_ready is high exactly on the cycle the word is captured into wbm_dat_o.
  assign wr_ready    = load && wbm_we_o;

`ifdef WBM_BURST_TIMEOUT_EN
  localparam int TW = $clog2(timeout_g + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(timeout_g - 1);
  localparam logic [TW-1:0] WD_ONE  = 1;

  logic [TW-1:0] wd_cnt;

  // Fires on the timeout_g-th consecutive cycle of an active cycle without an ack.
  assign tmo_hit = busy && !wbm_ack_i && (wd_cnt == WD_LAST);

  // Watchdog: counts busy cycles, restarts on every ack and whenever the bus is idle.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (!busy || wbm_ack_i) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_ONE;
    end
  end
`else
  logic unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign unused_timeout_cfg = ^timeout_g;
`endif

  // Read return path: one registered word per counted ack; an error in the same cycle suppresses it.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_dat   <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (ack_ok && !wbm_err_i && !wbm_we_o) begin
        rd_valid <= 1'b1;
        rd_dat   <= wbm_dat_i;
      end
    end
  end

  // Burst control FSM with all bus and status outputs registered.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tmo       <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_tga_o <= '0;
      wbm_dat_o <= '0;
      wbm_tgc_o <= 1'b0;
      wbm_tgd_o <= 1'b0;
      stb_cnt   <= '0;
      ack_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            state     <= ISSUE;
            wbm_cyc_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_tga_o <= cmd_len;
            wbm_tgc_o <= cmd_tgc;
            wbm_tgd_o <= cmd_tgd;
            stb_cnt   <= '0;
            ack_cnt   <= '0;
          end
        end

        ISSUE, WAIT_ACK: begin
          stb_cnt <= stb_cnt_nxt;
          ack_cnt <= ack_cnt_nxt;
          // Address advances only when the slave takes the strobe, so it holds under stall.
          if (accept) begin
            wbm_adr_o <= wbm_adr_o + ADR_ONE;
          end
          if (slot_free) begin
            wbm_stb_o <= load;
          end
          if (wr_ready) begin
            wbm_dat_o <= wr_dat;
          end

          if (abort) begin
            // Error takes priority over a same-cycle ack and over the watchdog.
            state     <= DONE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            done      <= 1'b1;
            err       <= wbm_err_i;
            tmo       <= tmo_hit && !wbm_err_i;
          end else if (ack_cnt_nxt == total) begin
            state     <= DONE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            done      <= 1'b1;
          end else if ((state == ISSUE) && (stb_cnt_nxt == total)) begin
            state <= WAIT_ACK;
          end
        end

        DONE: begin
          done      <= 1'b0;
          err       <= 1'b0;
          tmo       <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_stall_hold: assert property (@(posedge clock) disable iff (!rst)
    ((state == ISSUE) && wbm_stb_o && wbm_stall_i && !abort) |=>
      (wbm_stb_o && $stable(wbm_adr_o) && $stable(wbm_dat_o)));

  a_ack_bound: assert property (@(posedge clock) disable iff (!rst)
    ack_cnt <= stb_cnt);

  a_ready_idle: assert property (@(posedge clock) disable iff (!rst)
    cmd_ready |-> (state == IDLE));

endmodule

// File: tb/tb_wbm_burst_master.sv
// Directed bench for wbm_burst_master with a behavioural pipelined Wishbone slave.
// The slave acks one cycle after each accepted strobe, and can stall the first strobe, raise an error on the Nth ack, or withhold acks.
// The expected addresses, data and status values are computed by hand.
module tb_wbm_burst_master;

  logic       clock;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [9:0] cmd_adr;
  logic [8:0] cmd_len;
  logic       cmd_tgc;
  logic       cmd_tgd;
  logic [7:0] wr_dat;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_dat;
  logic       rd_valid;
  logic       done;
  logic       err;
  logic       tmo;
  logic       wbm_cyc_o;
  logic       wbm_stb_o;
  logic       wbm_we_o;
  logic [9:0] wbm_adr_o;
  logic [8:0] wbm_tga_o;
  logic [7:0] wbm_dat_o;
  logic       wbm_tgc_o;
  logic       wbm_tgd_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_stall_i;
  logic       wbm_ack_i;
  logic       wbm_err_i;

  wbm_burst_master #(
    .data_width_g(8),
    .addr_width_g(10),
    .blen_width_g(9),
    .timeout_g   (16)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_len    (cmd_len),
    .cmd_tgc    (cmd_tgc),
    .cmd_tgd    (cmd_tgd),
    .wr_dat     (wr_dat),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_dat     (rd_dat),
    .rd_valid   (rd_valid),
    .done       (done),
    .err        (err),
    .tmo        (tmo),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_tga_o  (wbm_tga_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_tgc_o  (wbm_tgc_o),
    .wbm_tgd_o  (wbm_tgd_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_stall_i(wbm_stall_i),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_err_i  (wbm_err_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave behaviour knobs and logs.
  int         stall_left = 0;
  int         err_at     = 0;
  bit         ack_en     = 1'b1;
  int         n_ack      = 0;
  bit         acc_prev   = 1'b0;
  logic [9:0] acc_adr    = '0;
  int         widx       = 0;
  bit         wr_take    = 1'b0;
  int         wr_cnt     = 0;
  int         done_cnt   = 0;
  int         cyc_cnt    = 0;
  logic       last_err   = 1'b0;
  logic       last_tmo   = 1'b0;
  logic       cyc_at_done = 1'b1;
  logic [9:0] adr_log[$];
  logic [7:0] dat_log[$];
  logic [9:0] stall_log[$];
  logic [7:0] rd_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rdata(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Behavioural slave, write-data source and output monitor; acts on the falling edge.
  always @(negedge clock) begin
    if (wr_take) begin
      widx++;
      wr_dat  = 8'hC0 + 8'(widx);
      wr_take = 1'b0;
    end
    if (acc_prev && ack_en && wbm_cyc_o) begin
      n_ack++;
      if (n_ack == err_at) begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b1;
      end else begin
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b0;
        wbm_dat_i = rdata(acc_adr);
      end
    end else begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
    end
    if (wbm_stb_o && stall_left > 0) begin
      wbm_stall_i = 1'b1;
      stall_left--;
      stall_log.push_back(wbm_adr_o);
    end else begin
      wbm_stall_i = 1'b0;
    end
    acc_prev = wbm_stb_o && !wbm_stall_i;
    if (acc_prev) begin
      acc_adr = wbm_adr_o;
      adr_log.push_back(wbm_adr_o);
      dat_log.push_back(wbm_dat_o);
    end
    if (wbm_cyc_o) cyc_cnt++;
    if (rd_valid) rd_log.push_back(rd_dat);
    if (done) begin
      done_cnt++;
      last_err    = err;
      last_tmo    = tmo;
      cyc_at_done = wbm_cyc_o;
    end
    #1;
    if (wr_ready) begin
      wr_cnt++;
      wr_take = 1'b1;
    end
  end

  task automatic start_burst(input logic we, input logic [9:0] adr, input logic [8:0] len,
                             input int stall_n, input int err_n);
    int n;
    @(negedge clock);
    #3;
    adr_log.delete();
    dat_log.delete();
    stall_log.delete();
    rd_log.delete();
    stall_left = stall_n;
    err_at     = err_n;
    n_ack      = 0;
    widx       = 0;
    wr_take    = 1'b0;
    wr_dat     = 8'hC0;
    wr_cnt     = 0;
    done_cnt   = 0;
    cyc_cnt    = 0;
    wr_valid   = we;
    cmd_we     = we;
    cmd_adr    = adr;
    cmd_len    = len;
    cmd_valid  = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clock);
      #3;
      n++;
    end
    check("cmd_ready_seen", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    #3;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      @(negedge clock);
      #3;
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_tgc = 1'b0; cmd_tgd = 1'b0;
    wr_dat = 8'hC0; wr_valid = 1'b0;
    wbm_dat_i = '0; wbm_stall_i = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;

    // Reset values
    #1 rst = 1'b0;
    #1;
    check("rst_cyc",       32'(wbm_cyc_o), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_adr",       32'(wbm_adr_o), 32'd0);
    check("rst_rd_dat",    32'(rd_dat),    32'd0);
    check("rst_done",      32'(done),      32'd0);
    repeat (3) @(negedge clock);
    rst = 1'b1;

    // Write burst 0x010, len 3, no stall, with tags
    cmd_tgc = 1'b1;
    cmd_tgd = 1'b0;
    start_burst(1'b1, 10'h010, 9'd3, 0, 0);
    check("w1_tga", 32'(wbm_tga_o), 32'd3);
    check("w1_tgc", 32'(wbm_tgc_o), 32'd1);
    check("w1_tgd", 32'(wbm_tgd_o), 32'd0);
    check("w1_we",  32'(wbm_we_o),  32'd1);
    wait_done(40);
    repeat (2) @(negedge clock);
    #3;
    check("w1_done_once", done_cnt, 1);
    check("w1_err",       32'(last_err), 32'd0);
    check("w1_tmo",       32'(last_tmo), 32'd0);
    check("w1_wr_ready",  wr_cnt, 4);
    check("w1_n_stb",     adr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w1_adr%0d", i), 32'((i < adr_log.size()) ? adr_log[i] : 10'h2AA), 32'h010 + i);
      check($sformatf("w1_dat%0d", i), 32'((i < dat_log.size()) ? dat_log[i] : 8'h00), 32'hC0 + i);
    end
    cmd_tgc = 1'b0;

    // Read burst 0x020, len 1, first strobe stalled 3 cycles
    start_burst(1'b0, 10'h020, 9'd1, 3, 0);
    wait_done(40);
    check("r1_done",    done_cnt, 1);
    check("r1_err",     32'(last_err), 32'd0);
    check("r1_stalls",  stall_log.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("r1_hold%0d", i), 32'((i < stall_log.size()) ? stall_log[i] : 10'h2AA), 32'h020);
    check("r1_n_stb",   adr_log.size(), 2);
    check("r1_adr1",    32'((adr_log.size() > 1) ? adr_log[1] : 10'h2AA), 32'h021);
    check("r1_n_rd",    rd_log.size(), 2);
    check("r1_rd0",     32'((rd_log.size() > 0) ? rd_log[0] : 8'h00), 32'h7A);
    check("r1_rd1",     32'((rd_log.size() > 1) ? rd_log[1] : 8'h00), 32'h7B);

    // Write burst wrapping at the top of the address space
    start_burst(1'b1, 10'h3FF, 9'd1, 0, 0);
    wait_done(40);
    check("w2_done",  done_cnt, 1);
    check("w2_n_stb", adr_log.size(), 2);
    check("w2_adr0",  32'((adr_log.size() > 0) ? adr_log[0] : 10'h2AA), 32'h3FF);
    check("w2_adr1",  32'((adr_log.size() > 1) ? adr_log[1] : 10'h2AA), 32'h000);

    // Read burst len 7 with an error on the third ack
    start_burst(1'b0, 10'h040, 9'd7, 0, 3);
    wait_done(40);
    check("e1_done",     done_cnt, 1);
    check("e1_err",      32'(last_err), 32'd1);
    check("e1_tmo",      32'(last_tmo), 32'd0);
    check("e1_cyc_low",  32'(cyc_at_done), 32'd0);
    check("e1_n_rd",     rd_log.size(), 2);
    check("e1_rd0",      32'((rd_log.size() > 0) ? rd_log[0] : 8'h00), 32'h1A);
    check("e1_rd1",      32'((rd_log.size() > 1) ? rd_log[1] : 8'h00), 32'h1B);

    // Slave never acks
    ack_en = 1'b0;
    start_burst(1'b0, 10'h100, 9'd3, 0, 0);
`ifdef WBM_BURST_TIMEOUT_EN
    wait_done(60);
    check("t1_done",    done_cnt, 1);
    check("t1_tmo",     32'(last_tmo), 32'd1);
    check("t1_err",     32'(last_err), 32'd0);
    check("t1_cyc_len", cyc_cnt, 16);
`else
    repeat (40) @(negedge clock);
    #3;
    check("t1_no_done", done_cnt, 0);
    check("t1_cyc_hi",  32'(wbm_cyc_o), 32'd1);
    check("t1_tmo",     32'(tmo), 32'd0);
`endif
    @(negedge clock);
    rst = 1'b0;
    #1;
    check("t1_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    @(negedge clock);
    rst = 1'b1;
    ack_en = 1'b1;

    // Reset asserted mid-write once two words are accepted
    cmd_tgc = 1'b1;
    cmd_tgd = 1'b1;
    start_burst(1'b1, 10'h080, 9'd3, 0, 0);
    for (int n = 0; n < 20 && adr_log.size() < 2; n++) begin
      @(negedge clock);
      #3;
    end
    check("m1_words", adr_log.size(), 2);
    rst = 1'b0;
    #1;
    check("m1_cyc",    32'(wbm_cyc_o), 32'd0);
    check("m1_stb",    32'(wbm_stb_o), 32'd0);
    check("m1_we",     32'(wbm_we_o),  32'd0);
    check("m1_adr",    32'(wbm_adr_o), 32'd0);
    check("m1_tga",    32'(wbm_tga_o), 32'd0);
    check("m1_dat",    32'(wbm_dat_o), 32'd0);
    check("m1_tags",   32'({wbm_tgc_o, wbm_tgd_o}), 32'd0);
    check("m1_wr_rdy", 32'(wr_ready),  32'd0);
    check("m1_done",   32'(done),      32'd0);
    @(negedge clock);
    rst = 1'b1;
    cmd_tgc = 1'b0;
    cmd_tgd = 1'b0;

    // Single-word read after reset recovery
    start_burst(1'b0, 10'h155, 9'd0, 0, 0);
    wait_done(40);
    check("s1_done",  done_cnt, 1);
    check("s1_err",   32'(last_err), 32'd0);
    check("s1_n_stb", adr_log.size(), 1);
    check("s1_adr0",  32'((adr_log.size() > 0) ? adr_log[0] : 10'h2AA), 32'h155);
    check("s1_n_rd",  rd_log.size(), 1);
    check("s1_rd0",   32'((rd_log.size() > 0) ? rd_log[0] : 8'h00), 32'h0F);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
